param_fifo: RTL

- Synchronous single-clock FIFO with parametrised data width and depth.
- Provides full/empty/count status and a registered read port with a valid strobe.
- Asynchronous active-low reset.
- Drop-in successor to the fixed 4-entry buffer: it sits between the wide data producer and its consumer in the same clock domain, and adds flow-control flags so the caller no longer tracks occupancy externally.

---
 rtl/param_fifo_if.sv | 39 +++
 rtl/param_fifo.sv | 88 ++++++++
 2 files changed

// File: rtl/param_fifo_if.sv
// Handshake bundle between a producer/consumer pair and param_fifo.
// PARAM_FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow outputs.
interface param_fifo_if #(
  parameter int width_data = 288,
  parameter int depth      = 4
);
  localparam int addr_w = $clog2(depth);

  logic                  write_en;
  logic [width_data-1:0] write_dt;
  logic                  read_en;
  logic [width_data-1:0] read_dt;
  logic                  read_valid;
  logic                  full;
  logic                  empty;
  logic [addr_w:0]       count;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_en, write_dt, read_en,
    input  read_dt, read_valid, full, empty, count, overflow, underflow
  );
  modport slave (
    input  write_en, write_dt, read_en,
    output read_dt, read_valid, full, empty, count, overflow, underflow
  );
`else
  modport master (
    output write_en, write_dt, read_en,
    input  read_dt, read_valid, full, empty, count
  );
  modport slave (
    input  write_en, write_dt, read_en,
    output read_dt, read_valid, full, empty, count
  );
`endif
endinterface

// File: rtl/param_fifo.sv
// Single-clock FIFO with registered read port, read_valid strobe and status flags.
// Optional sticky error flags under PARAM_FIFO_ERR_FLAGS_EN.
module param_fifo #(
  parameter int width_data = 288,
  parameter int depth      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  param_fifo_if.slave bus
);
  localparam int addr_w = $clog2(depth);

  logic [addr_w:0]       wr_ptr_q, wr_ptr_d;
  logic [addr_w:0]       rd_ptr_q, rd_ptr_d;
  logic [addr_w:0]       count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [width_data-1:0] read_dt_q;
  logic                  read_valid_q;
  logic [width_data-1:0] mem_q [depth];
  logic                  rd_acc;
  logic                  wr_acc;

  // A write into a full FIFO is taken only when a read frees a slot on the same edge.
  always_comb begin
    rd_acc   = bus.read_en && !empty_q;
    wr_acc   = bus.write_en && (!full_q || rd_acc);
    wr_ptr_d = wr_ptr_q + {{addr_w{1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{addr_w{1'b0}}, rd_acc};
    count_d  = wr_ptr_d - rd_ptr_d;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[addr_w] != rd_ptr_d[addr_w]) &&
               (wr_ptr_d[addr_w-1:0] == rd_ptr_d[addr_w-1:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      read_dt_q    <= '0;
      read_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      read_valid_q <= rd_acc;
      if (rd_acc) begin
        read_dt_q <= mem_q[rd_ptr_q[addr_w-1:0]];
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[addr_w-1:0]] <= bus.write_dt;
    end
  end

  assign bus.read_dt    = read_dt_q;
  assign bus.read_valid = read_valid_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.count      = count_q;

`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  | (bus.write_en && !wr_acc);
      underflow_q <= underflow_q | (bus.read_en && empty_q);
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule
